// File: rtl/glitch_sweep_ctrl_pkg.sv
// Shared types for the glitch sweep controller and the glitch engine.
// Holds the delay/duration field widths, the controller state encoding,
// the latched sweep configuration and a helper that normalises zero fields.
package glitch_sweep_ctrl_pkg;

  localparam int unsigned DelayW = 21;
  localparam int unsigned DurW   = 7;
  localparam int unsigned StepW  = 8;
  localparam int unsigned RepW   = 4;
  localparam int unsigned AttW   = 16;

  typedef logic [DelayW-1:0] delay_t;
  typedef logic [DurW-1:0]   dur_t;
  typedef logic [StepW-1:0]  step_t;
  typedef logic [RepW-1:0]   rep_t;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StArm,
    StWaitStart,
    StWaitEnd,
    StCooldown,
    StAdvance,
    StDone
  } sweep_state_e;

  typedef struct packed {
    delay_t delay_lo;
    delay_t delay_hi;
    step_t  delay_step;
    dur_t   dur_lo;
    dur_t   dur_hi;
    rep_t   repeats;
  } sweep_cfg_t;

  // A zero step or repeat count means "one".
  function automatic sweep_cfg_t norm_cfg(input delay_t delay_lo, input delay_t delay_hi,
                                          input step_t delay_step, input dur_t dur_lo,
                                          input dur_t dur_hi, input rep_t repeats);
    sweep_cfg_t c;
    c.delay_lo   = delay_lo;
    c.delay_hi   = delay_hi;
    c.delay_step = (delay_step == '0) ? step_t'(1) : delay_step;
    c.dur_lo     = dur_lo;
    c.dur_hi     = dur_hi;
    c.repeats    = (repeats == '0) ? rep_t'(1) : repeats;
    return c;
  endfunction

endpackage

// File: rtl/glitch_sweep_ctrl_if.sv
// Controller <-> glitch engine link.
//   arm          : one-cycle request to fire one glitch
//   cfg_delay    : delay the engine should use
//   cfg_duration : duration the engine should use
//   eng_active   : engine is out of its idle/reset state
// master = sweep controller, slave = glitch engine.
interface glitch_sweep_ctrl_if;
  import glitch_sweep_ctrl_pkg::*;

  logic   arm;
  delay_t cfg_delay;
  dur_t   cfg_duration;
  logic   eng_active;

  modport master (
    output arm,
    output cfg_delay,
    output cfg_duration,
    input  eng_active
  );

  modport slave (
    input  arm,
    input  cfg_delay,
    input  cfg_duration,
    output eng_active
  );
endinterface

// File: rtl/sweep_point_iter.sv
// Sweep point iterator: given the current (delay, duration) point returns the
// next one. Delay is the inner loop; once it would pass delay_hi it restarts at
// delay_lo and duration steps by one. sweep_end flags that the duration step
// would pass dur_hi or wrap past the field maximum.
// Ports:
//   cur_delay/cur_duration : current point
//   delay_lo/delay_hi      : inclusive delay bounds
//   delay_step             : delay increment (already non-zero)
//   dur_hi                 : inclusive upper duration bound
//   next_delay/next_duration, sweep_end : result
module sweep_point_iter
  import glitch_sweep_ctrl_pkg::*;
(
  input  delay_t cur_delay,
  input  dur_t   cur_duration,
  input  delay_t delay_lo,
  input  delay_t delay_hi,
  input  step_t  delay_step,
  input  dur_t   dur_hi,
  output delay_t next_delay,
  output dur_t   next_duration,
  output logic   sweep_end
);

  // One extra bit on each sum so overflow compares as "past the bound".
  logic [DelayW:0] delay_sum;
  logic [DurW:0]   dur_sum;

  always_comb begin
    delay_sum = {1'b0, cur_delay} + (DelayW + 1)'(delay_step);
    dur_sum   = {1'b0, cur_duration} + (DurW + 1)'(1);
    if (delay_sum <= {1'b0, delay_hi}) begin
      next_delay    = delay_sum[DelayW-1:0];
      next_duration = cur_duration;
      sweep_end     = 1'b0;
    end else begin
      next_delay    = delay_lo;
      next_duration = dur_sum[DurW-1:0];
      sweep_end     = (dur_sum > {1'b0, dur_hi});
    end
  end

endmodule

// File: rtl/glitch_sweep_ctrl.sv
// Glitch sweep controller: walks a (delay, duration) grid, firing the glitch
// engine `repeats` times per point, and stops at the end of the grid, on the
// first target fault (after that attempt's cooldown) or on abort.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start, abort             : begin sweep (pulse) / force DONE (level)
//   delay_lo/hi, delay_step  : delay sweep, sampled on start
//   dur_lo/hi, repeats       : duration sweep and attempts per point, sampled on start
//   target_fault             : async fault indication from the target
//   eng                      : engine link (arm, cfg_delay, cfg_duration, eng_active)
//   busy, done               : status
//   hit, hit_delay/duration  : first fault and the point that produced it
//   attempts, timeout_err    : attempt count (saturating) and sticky engine timeout
module glitch_sweep_ctrl
  import glitch_sweep_ctrl_pkg::*;
#(
  parameter int unsigned COOLDOWN = 16,
  parameter int unsigned TIMEOUT  = 1048575
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  delay_t                     delay_lo,
  input  delay_t                     delay_hi,
  input  step_t                      delay_step,
  input  dur_t                       dur_lo,
  input  dur_t                       dur_hi,
  input  rep_t                       repeats,
  input  logic                       target_fault,
  glitch_sweep_ctrl_if.master        eng,
  output logic                       busy,
  output logic                       done,
  output logic                       hit,
  output delay_t                     hit_delay,
  output dur_t                       hit_duration,
  output logic [AttW-1:0]            attempts,
  output logic                       timeout_err
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam int unsigned CdW  = $clog2(COOLDOWN + 1);

  sweep_state_e    state_q, state_d;
  sweep_cfg_t      cfg_q, cfg_d;
  delay_t          cur_delay_q, cur_delay_d;
  dur_t            cur_dur_q, cur_dur_d;
  rep_t            rep_q, rep_d;
  logic [AttW-1:0] attempts_q, attempts_d;
  logic            hit_q, hit_d;
  delay_t          hit_delay_q, hit_delay_d;
  dur_t            hit_dur_q, hit_dur_d;
  logic            tmo_err_q, tmo_err_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [CdW-1:0]  cd_cnt_q, cd_cnt_d;
  logic [1:0]      fault_sync_q;

  logic   fault_now, load_bad, tmo_last, cd_last, rep_more;
  delay_t nxt_delay;
  dur_t   nxt_dur;
  logic   sweep_end;

  sweep_point_iter u_iter (
    .cur_delay     (cur_delay_q),
    .cur_duration  (cur_dur_q),
    .delay_lo      (cfg_q.delay_lo),
    .delay_hi      (cfg_q.delay_hi),
    .delay_step    (cfg_q.delay_step),
    .dur_hi        (cfg_q.dur_hi),
    .next_delay    (nxt_delay),
    .next_duration (nxt_dur),
    .sweep_end     (sweep_end)
  );

  always_comb begin
    fault_now = fault_sync_q[1] && (state_q == StWaitEnd || state_q == StCooldown);
    load_bad  = (cfg_q.delay_lo > cfg_q.delay_hi) || (cfg_q.dur_lo > cfg_q.dur_hi);
    tmo_last  = (tmo_cnt_q == TmoW'(TIMEOUT - 1));
    cd_last   = (cd_cnt_q == CdW'(COOLDOWN - 1));
    rep_more  = ((RepW + 1)'(rep_q) + (RepW + 1)'(1)) < (RepW + 1)'(cfg_q.repeats);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StLoad;
      StLoad:         state_d = load_bad ? StDone : StArm;
      StArm:          state_d = StWaitStart;
      StWaitStart: begin
        if (tmo_last)            state_d = StCooldown;
        else if (eng.eng_active) state_d = StWaitEnd;
      end
      StWaitEnd:      if (tmo_last || !eng.eng_active) state_d = StCooldown;
      StCooldown: begin
        // A fault seen on this very cycle must also end the sweep.
        if (cd_last) state_d = (hit_q || fault_now) ? StDone : StAdvance;
      end
      StAdvance:      state_d = (rep_more || !sweep_end) ? StArm : StDone;
      default:        state_d = StIdle;
    endcase
    if (abort && busy) state_d = StDone;
  end

  // Outputs decoded from the current state
  always_comb begin
    busy    = !(state_q == StIdle || state_q == StDone);
    done    = (state_q == StDone);
    eng.arm = (state_q == StArm) && !abort && !rst;
  end

  // Datapath next-state
  always_comb begin
    cfg_d       = cfg_q;
    cur_delay_d = cur_delay_q;
    cur_dur_d   = cur_dur_q;
    rep_d       = rep_q;
    attempts_d  = attempts_q;
    hit_d       = hit_q;
    hit_delay_d = hit_delay_q;
    hit_dur_d   = hit_dur_q;
    tmo_err_d   = tmo_err_q;
    // Counters idle at zero so they are already cleared on state entry.
    tmo_cnt_d   = '0;
    cd_cnt_d    = '0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          cfg_d       = norm_cfg(delay_lo, delay_hi, delay_step, dur_lo, dur_hi, repeats);
          attempts_d  = '0;
          hit_d       = 1'b0;
          hit_delay_d = '0;
          hit_dur_d   = '0;
          tmo_err_d   = 1'b0;
        end
      end
      StLoad: begin
        cur_delay_d = cfg_q.delay_lo;
        cur_dur_d   = cfg_q.dur_lo;
        rep_d       = '0;
      end
      StArm: begin
        if (!abort && attempts_q != '1) attempts_d = attempts_q + AttW'(1);
      end
      StWaitStart, StWaitEnd: begin
        if (tmo_last) tmo_err_d = 1'b1;
        else          tmo_cnt_d = tmo_cnt_q + TmoW'(1);
      end
      StCooldown: begin
        if (!cd_last) cd_cnt_d = cd_cnt_q + CdW'(1);
      end
      StAdvance: begin
        if (rep_more) begin
          rep_d = rep_q + RepW'(1);
        end else begin
          rep_d = '0;
          // Leave the last point on the outputs when the grid is exhausted.
          if (!sweep_end) begin
            cur_delay_d = nxt_delay;
            cur_dur_d   = nxt_dur;
          end
        end
      end
      default: ;
    endcase
    if (fault_now) begin
      hit_d = 1'b1;
      if (!hit_q) begin
        hit_delay_d = cur_delay_q;
        hit_dur_d   = cur_dur_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q        <= '0;
      cur_delay_q  <= '0;
      cur_dur_q    <= '0;
      rep_q        <= '0;
      attempts_q   <= '0;
      hit_q        <= 1'b0;
      hit_delay_q  <= '0;
      hit_dur_q    <= '0;
      tmo_err_q    <= 1'b0;
      tmo_cnt_q    <= '0;
      cd_cnt_q     <= '0;
      fault_sync_q <= '0;
    end else begin
      cfg_q        <= cfg_d;
      cur_delay_q  <= cur_delay_d;
      cur_dur_q    <= cur_dur_d;
      rep_q        <= rep_d;
      attempts_q   <= attempts_d;
      hit_q        <= hit_d;
      hit_delay_q  <= hit_delay_d;
      hit_dur_q    <= hit_dur_d;
      tmo_err_q    <= tmo_err_d;
      tmo_cnt_q    <= tmo_cnt_d;
      cd_cnt_q     <= cd_cnt_d;
      fault_sync_q <= {fault_sync_q[0], target_fault};
    end
  end

  assign eng.cfg_delay    = cur_delay_q;
  assign eng.cfg_duration = cur_dur_q;
  assign hit              = hit_q;
  assign hit_delay        = hit_delay_q;
  assign hit_duration     = hit_dur_q;
  assign attempts         = attempts_q;
  assign timeout_err      = tmo_err_q;

endmodule

// File: tb/tb_glitch_sweep_ctrl.sv
module tb_glitch_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort, target_fault;
  logic [20:0] delay_lo, delay_hi, hit_delay;
  logic [7:0]  delay_step;
  logic [6:0]  dur_lo, dur_hi, hit_duration;
  logic [3:0]  repeats;
  logic        busy, done, hit, timeout_err;
  logic [15:0] attempts;

  glitch_sweep_ctrl_if eng_if ();

  glitch_sweep_ctrl #(
    .COOLDOWN (4),
    .TIMEOUT  (50)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .delay_lo     (delay_lo),
    .delay_hi     (delay_hi),
    .delay_step   (delay_step),
    .dur_lo       (dur_lo),
    .dur_hi       (dur_hi),
    .repeats      (repeats),
    .target_fault (target_fault),
    .eng          (eng_if),
    .busy         (busy),
    .done         (done),
    .hit          (hit),
    .hit_delay    (hit_delay),
    .hit_duration (hit_duration),
    .attempts     (attempts),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct { int d; int u; } pt_t;
  typedef struct { bit hit; int hd; int hu; int att; bit tmo; } res_t;

  pt_t  exp_pts[$];
  res_t exp_res[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   eng_live = 1'b1;
  int   fault_at = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: enumerate the grid with plain loops, duration outer.
  task automatic plan(input int dlo, input int dhi, input int step, input int ulo,
                      input int uhi, input int reps, input int fat, input bit tmo);
    int   st, rp, n;
    bit   stop;
    res_t r;
    pt_t  p;
    st = (step == 0) ? 1 : step;
    rp = (reps == 0) ? 1 : reps;
    n = 0;
    stop = 0;
    r = '{hit: 0, hd: 0, hu: 0, att: 0, tmo: 0};
    if (dlo <= dhi && ulo <= uhi) begin
      for (int uu = ulo; uu <= uhi && !stop; uu++)
        for (int dd = dlo; dd <= dhi && !stop; dd += st)
          for (int k = 0; k < rp && !stop; k++) begin
            n++;
            p.d = dd;
            p.u = uu;
            exp_pts.push_back(p);
            if (n == fat) begin
              stop = 1;
              r.hit = 1;
              r.hd = dd;
              r.hu = uu;
            end
          end
    end
    r.att = n;
    r.tmo = tmo && (n > 0);
    exp_res.push_back(r);
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (!done && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("done_reached", done, 1);
  endtask

  task automatic run_sweep(input int dlo, input int dhi, input int step, input int ulo,
                           input int uhi, input int reps, input int fat, input bit live);
    int cnt;
    eng_live = live;
    fault_at = fat;
    plan(dlo, dhi, step, ulo, uhi, reps, fat, !live);
    delay_lo = 21'(dlo);
    delay_hi = 21'(dhi);
    delay_step = 8'(step);
    dur_lo = 7'(ulo);
    dur_hi = 7'(uhi);
    repeats = 4'(reps);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("busy_in_sweep", busy, 1);
    if (!live) begin
      cnt = 0;
      while (!eng_if.arm && cnt < 10) begin
        @(negedge clk);
        cnt++;
      end
      cnt = 0;
      while (cnt < 200) begin
        @(negedge clk);
        if (timeout_err) break;
        cnt++;
      end
      check("timeout_wait_cycles", cnt, 50);
    end
    wait_done(30000);
    repeat (3) tick();
  endtask

  // Engine model: rises two cycles after arm, stays active five cycles,
  // and raises the target fault on the chosen attempt.
  initial begin : engine
    int n_arm;
    n_arm = 0;
    eng_if.eng_active = 1'b0;
    target_fault = 1'b0;
    forever begin
      @(negedge clk);
      if (start) n_arm = 0;
      if (eng_if.arm) begin
        n_arm++;
        if (eng_live) begin
          tick();
          tick();
          eng_if.eng_active = 1'b1;
          if (n_arm == fault_at) target_fault = 1'b1;
          repeat (5) tick();
          eng_if.eng_active = 1'b0;
          target_fault = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor
  initial begin : monitor
    logic arm_prev, done_prev;
    pt_t  p;
    res_t r;
    arm_prev = 1'b0;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (eng_if.arm) begin
        check("arm_one_cycle", arm_prev, 0);
        if (exp_pts.size() == 0) begin
          check("arm_unexpected", eng_if.arm, 0);
        end else begin
          p = exp_pts.pop_front();
          check("arm_delay", eng_if.cfg_delay, p.d);
          check("arm_duration", eng_if.cfg_duration, p.u);
        end
      end
      if (done && !done_prev) begin
        if (exp_res.size() == 0) begin
          check("done_unexpected", done, 0);
        end else begin
          r = exp_res.pop_front();
          check("arms_missing", exp_pts.size(), 0);
          check("hit", hit, r.hit);
          check("hit_delay", hit_delay, r.hd);
          check("hit_duration", hit_duration, r.hu);
          check("attempts", attempts, r.att);
          check("timeout_err", timeout_err, r.tmo);
        end
      end
      arm_prev = eng_if.arm;
      done_prev = done;
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int dlo, dhi, step, ulo, uhi, reps, fat;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    delay_lo = '0;
    delay_hi = '0;
    delay_step = '0;
    dur_lo = '0;
    dur_hi = '0;
    repeats = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_flags", {eng_if.arm, busy, done, hit, timeout_err}, 0);
    check("rst_attempts", attempts, 0);
    check("rst_hit_point", {hit_delay, hit_duration}, 0);
    check("rst_cfg", {eng_if.cfg_delay, eng_if.cfg_duration}, 0);
    tick();
    rst = 1'b0;

    run_sweep(10, 30, 10, 2, 3, 1, 0, 1);
    run_sweep(0, 4, 0, 1, 1, 2, 0, 1);
    run_sweep(10, 30, 10, 2, 3, 1, 3, 1);
    run_sweep(5, 4, 1, 0, 0, 1, 0, 1);
    run_sweep(2097150, 2097151, 200, 126, 127, 1, 0, 1);

    for (int i = 0; i < 6; i++) begin
      dlo = $urandom_range(0, 1000);
      dhi = dlo + $urandom_range(0, 20);
      step = $urandom_range(0, 12);
      ulo = $urandom_range(0, 125);
      uhi = ulo + $urandom_range(0, 2);
      reps = $urandom_range(0, 3);
      fat = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 8) : 0;
      run_sweep(dlo, dhi, step, ulo, uhi, reps, fat, 1);
    end

    // Engine never starts: every attempt times out, sweep still visits both points.
    run_sweep(0, 4, 4, 1, 1, 1, 0, 0);

    // Abort while the engine is mid-glitch.
    eng_live = 1'b1;
    fault_at = 0;
    begin
      pt_t  p;
      res_t r;
      int   cnt;
      p.d = 10;
      p.u = 2;
      exp_pts.push_back(p);
      r = '{hit: 0, hd: 0, hu: 0, att: 1, tmo: 0};
      exp_res.push_back(r);
      delay_lo = 21'd10;
      delay_hi = 21'd30;
      delay_step = 8'd10;
      dur_lo = 7'd2;
      dur_hi = 7'd3;
      repeats = 4'd1;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      cnt = 0;
      while (!eng_if.eng_active && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      check("engine_started", eng_if.eng_active, 1);
      tick();
      abort = 1'b1;
      @(negedge clk);
      check("abort_not_done_yet", done, 0);
      tick();
      abort = 1'b0;
      @(negedge clk);
      check("abort_done_next_cycle", done, 1);
      repeat (10) tick();
    end

    // Reset while in ARM: no arm pulse, everything cleared.
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("arm_masked_by_rst", eng_if.arm, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_flags", {eng_if.arm, busy, done, hit, timeout_err}, 0);
    check("post_rst_attempts", attempts, 0);
    check("post_rst_hit_point", {hit_delay, hit_duration}, 0);
    check("post_rst_cfg", {eng_if.cfg_delay, eng_if.cfg_duration}, 0);

    // Reset wins over start and abort in the same cycle.
    tick();
    rst = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("rst_overrides_start", {busy, done}, 0);
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
